// File: rtl/force_override_sched_if.sv
// force_override_sched_if
//   Groups the force-request side and the bus pass-through side of the
//   force_override_sched block.
//   master : request source / bus source / consumer (drives req*, abort, bus*_in)
//   slave  : the scheduler (drives gnt, forced, done, bus*_out)
//   Signals:
//     req       NREQ          per-requester force request
//     req_val   NREQ*(WA+WB)  force value, slice i = {busa,busb}
//     req_cyc   NREQ*CW       hold cycles per requester (0 behaves as 1)
//     abort     1             early release of the active force
//     busa_in   WA            functional busa source
//     busb_in   WB            functional busb source
//     busa_out  WA            registered busa to consumers
//     busb_out  WB            registered busb to consumers
//     gnt       NREQ          one-hot, one-cycle acceptance pulse
//     forced    1             high while an override is active
//     done      1             one-cycle pulse on release
interface force_override_sched_if #(
  parameter int WA   = 4,
  parameter int WB   = 4,
  parameter int NREQ = 3,
  parameter int CW   = 4
);
  logic [NREQ-1:0]         req;
  logic [NREQ*(WA+WB)-1:0] req_val;
  logic [NREQ*CW-1:0]      req_cyc;
  logic                    abort;
  logic [WA-1:0]           busa_in;
  logic [WB-1:0]           busb_in;
  logic [WA-1:0]           busa_out;
  logic [WB-1:0]           busb_out;
  logic [NREQ-1:0]         gnt;
  logic                    forced;
  logic                    done;

  modport master (
    output req, req_val, req_cyc, abort, busa_in, busb_in,
    input  busa_out, busb_out, gnt, forced, done
  );

  modport slave (
    input  req, req_val, req_cyc, abort, busa_in, busb_in,
    output busa_out, busb_out, gnt, forced, done
  );
endinterface

// File: rtl/force_override_sched.sv
// force_override_sched
//   Round-robin scheduler that grants NREQ requesters a timed override of the
//   {busa,busb} pair. A grant latches the requester's value and hold count,
//   drives the value onto both buses for max(req_cyc,1) cycles (or until
//   abort), then hands the buses back to their functional sources.
//   Ports:
//     clk    clock, all state updates on posedge
//     reset  synchronous active-high reset
//     bus    force_override_sched_if.slave (requests, bus in/out, status)
module force_override_sched #(
  parameter int WA   = 4,
  parameter int WB   = 4,
  parameter int NREQ = 3,
  parameter int CW   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  force_override_sched_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int VW = WA + WB;

  typedef enum logic [1:0] {IDLE, FORCE, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]   val_q, val_d;
  logic [WA-1:0]   busa_q, busa_d;
  logic [WB-1:0]   busb_q, busb_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            forced_q, forced_d;
  logic            done_q, done_d;
  logic [PW:0]     pick;
  logic [CW-1:0]   cyc;

  // First set request scanning upward from the pointer with wrap.
  // MSB of the result flags that a request was found. Scanning from the far
  // end down lets the closest candidate overwrite the result last.
  function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [PW-1:0]   p);
    logic [PW:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(p) + k) % NREQ);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    val_d    = val_q;
    gnt_d    = '0;
    forced_d = 1'b0;
    done_d   = 1'b0;
    busa_d   = bus.busa_in;
    busb_d   = bus.busb_in;
    cyc      = '0;
    pick     = rr_pick(bus.req, ptr_q);

    unique case (state_q)
      IDLE: begin
        if (pick[PW]) begin
          sel_d = pick[PW-1:0];
          val_d = bus.req_val[int'(pick[PW-1:0])*VW +: VW];
          cyc   = bus.req_cyc[int'(pick[PW-1:0])*CW +: CW];
          // A zero hold request still yields one forced cycle.
          cnt_d = (cyc == '0) ? '0 : cyc - 1'b1;
          gnt_d = NREQ'(1) << pick[PW-1:0];
          forced_d = 1'b1;
          {busa_d, busb_d} = val_d;
          state_d = FORCE;
        end
      end
      FORCE: begin
        if (cnt_q == '0 || bus.abort) begin
          done_d  = 1'b1;
          ptr_d   = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
          state_d = RELEASE;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          forced_d = 1'b1;
          {busa_d, busb_d} = val_q;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and scheduler state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      val_q    <= '0;
      busa_q   <= '0;
      busb_q   <= '0;
      gnt_q    <= '0;
      forced_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      busa_q   <= busa_d;
      busb_q   <= busb_d;
      gnt_q    <= gnt_d;
      forced_q <= forced_d;
      done_q   <= done_d;
    end
  end

  assign bus.busa_out = busa_q;
  assign bus.busb_out = busb_q;
  assign bus.gnt      = gnt_q;
  assign bus.forced   = forced_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_force_override_sched.sv
// tb_force_override_sched
//   Directed bench for force_override_sched. Observed outputs are packed as
//   {gnt[2:0], forced, done, busa_out, busb_out} and compared against
//   hand-computed vectors one cycle at a time.
module tb_force_override_sched;
  localparam int WA = 4, WB = 4, NREQ = 3, CW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  force_override_sched_if #(.WA(WA), .WB(WB), .NREQ(NREQ), .CW(CW)) bif ();

  force_override_sched #(.WA(WA), .WB(WB), .NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  wire [12:0] obs = {bif.gnt, bif.forced, bif.done, bif.busa_out, bif.busb_out};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bif.req = '0; bif.req_val = '0; bif.req_cyc = '0; bif.abort = 1'b0;
    bif.busa_in = 4'h5; bif.busb_in = 4'h7;
    reset = 1'b1;
    tick(); tick();
    n_checks++;
    if (obs !== 13'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 13'h0);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (obs !== {3'b000, 2'b00, 8'h57}) begin
      n_fail++; $display("FAIL reset_passthru: got %h expected %h", obs, {3'b000, 2'b00, 8'h57});
    end
  endtask

  task automatic test_force_basic();
    bif.req = 3'b001; bif.req_val = {8'h00, 8'h00, 8'hFD}; bif.req_cyc = {4'd0, 4'd0, 4'd3};
    tick();
    n_checks++;
    if (obs !== {3'b001, 2'b10, 8'hFD}) begin
      n_fail++; $display("FAIL basic_grant: got %h expected %h", obs, {3'b001, 2'b10, 8'hFD});
    end
    // Changes after the grant must not reach the bus.
    bif.req = '0; bif.req_val = {8'h00, 8'h00, 8'h11}; bif.req_cyc = {4'd0, 4'd0, 4'd9};
    for (int k = 2; k <= 3; k++) begin
      tick();
      n_checks++;
      if (obs !== {3'b000, 2'b10, 8'hFD}) begin
        n_fail++; $display("FAIL basic_hold%0d: got %h expected %h", k, obs, {3'b000, 2'b10, 8'hFD});
      end
    end
    tick();
    n_checks++;
    if (obs !== {3'b000, 2'b01, 8'h57}) begin
      n_fail++; $display("FAIL basic_release: got %h expected %h", obs, {3'b000, 2'b01, 8'h57});
    end
    tick();
    n_checks++;
    if (obs !== {3'b000, 2'b00, 8'h57}) begin
      n_fail++; $display("FAIL basic_idle: got %h expected %h", obs, {3'b000, 2'b00, 8'h57});
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bif.req = 3'b111; bif.req_val = {8'h3A, 8'h29, 8'h18}; bif.req_cyc = {4'd1, 4'd1, 4'd1};
    for (int g = 0; g < 4; g++) begin
      int          idx;
      int          waited;
      logic [7:0]  v;
      logic [2:0]  eg;
      idx    = g % NREQ;
      v      = 8'h18 + 8'(idx) * 8'h11;
      eg     = 3'(1 << idx);
      waited = 0;
      tick();
      while (bif.gnt == 3'b000 && waited < 6) begin
        tick();
        waited++;
      end
      n_checks++;
      if (obs !== {eg, 2'b10, v}) begin
        n_fail++; $display("FAIL rr_grant%0d: got %h expected %h", g, obs, {eg, 2'b10, v});
      end
      tick();
      n_checks++;
      if (obs !== {3'b000, 2'b01, 8'h57}) begin
        n_fail++; $display("FAIL rr_done%0d: got %h expected %h", g, obs, {3'b000, 2'b01, 8'h57});
      end
    end
    bif.req = '0;
    tick(); tick();
  endtask

  task automatic test_abort();
    bif.req = 3'b010; bif.req_val = {8'h00, 8'hC4, 8'h00}; bif.req_cyc = {4'd0, 4'd8, 4'd0};
    tick();
    n_checks++;
    if (obs !== {3'b010, 2'b10, 8'hC4}) begin
      n_fail++; $display("FAIL abort_grant: got %h expected %h", obs, {3'b010, 2'b10, 8'hC4});
    end
    bif.req = '0;
    tick();
    tick();
    n_checks++;
    if (obs !== {3'b000, 2'b10, 8'hC4}) begin
      n_fail++; $display("FAIL abort_hold: got %h expected %h", obs, {3'b000, 2'b10, 8'hC4});
    end
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;
    n_checks++;
    if (obs !== {3'b000, 2'b01, 8'h57}) begin
      n_fail++; $display("FAIL abort_release: got %h expected %h", obs, {3'b000, 2'b01, 8'h57});
    end
    tick();
    n_checks++;
    if (obs !== {3'b000, 2'b00, 8'h57}) begin
      n_fail++; $display("FAIL abort_single_done: got %h expected %h", obs, {3'b000, 2'b00, 8'h57});
    end
  endtask

  task automatic test_abort_on_gnt();
    // abort is high in IDLE (ignored) and stays high through the grant cycle.
    bif.abort = 1'b1;
    bif.req = 3'b100; bif.req_val = {8'h6B, 8'h00, 8'h00}; bif.req_cyc = {4'd5, 4'd0, 4'd0};
    tick();
    n_checks++;
    if (obs !== {3'b100, 2'b10, 8'h6B}) begin
      n_fail++; $display("FAIL abort_gnt_grant: got %h expected %h", obs, {3'b100, 2'b10, 8'h6B});
    end
    bif.req = '0;
    tick();
    bif.abort = 1'b0;
    n_checks++;
    if (obs !== {3'b000, 2'b01, 8'h57}) begin
      n_fail++; $display("FAIL abort_gnt_release: got %h expected %h", obs, {3'b000, 2'b01, 8'h57});
    end
    tick();
  endtask

  task automatic test_cyc0();
    bif.req = 3'b001; bif.req_val = {8'h00, 8'h00, 8'h92}; bif.req_cyc = '0;
    tick();
    n_checks++;
    if (obs !== {3'b001, 2'b10, 8'h92}) begin
      n_fail++; $display("FAIL cyc0_grant: got %h expected %h", obs, {3'b001, 2'b10, 8'h92});
    end
    bif.req = '0;
    tick();
    n_checks++;
    if (obs !== {3'b000, 2'b01, 8'h57}) begin
      n_fail++; $display("FAIL cyc0_release: got %h expected %h", obs, {3'b000, 2'b01, 8'h57});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bif.req = 3'b010; bif.req_val = {8'h00, 8'hE1, 8'h00}; bif.req_cyc = {4'd0, 4'd8, 4'd0};
    tick();
    n_checks++;
    if (obs !== {3'b010, 2'b10, 8'hE1}) begin
      n_fail++; $display("FAIL midrst_grant: got %h expected %h", obs, {3'b010, 2'b10, 8'hE1});
    end
    bif.req = '0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (obs !== 13'h0) begin
      n_fail++; $display("FAIL midrst_zero: got %h expected %h", obs, 13'h0);
    end
    tick();
    n_checks++;
    if (obs !== {3'b000, 2'b00, 8'h57}) begin
      n_fail++; $display("FAIL midrst_idle: got %h expected %h", obs, {3'b000, 2'b00, 8'h57});
    end
    bif.busa_in = 4'hA; bif.busb_in = 4'h3;
    tick();
    n_checks++;
    if (obs !== {3'b000, 2'b00, 8'hA3}) begin
      n_fail++; $display("FAIL midrst_follow: got %h expected %h", obs, {3'b000, 2'b00, 8'hA3});
    end
  endtask

  initial begin
    test_reset();
    test_force_basic();
    test_round_robin();
    test_abort();
    test_abort_on_gnt();
    test_cyc0();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
